lj_rx: RTL and testbench
========================

LJ_RX -- requirements
Module: lj_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of clk flops synchronising lrck, bck and sdi (legal values 2-3).
REQ-002 SHALL have port clk, input, 1, system clock, at least 8x the bck frequency.
REQ-003 SHALL have port reset_n, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port lrck, input, 1, external frame clock; high = left channel, low = right channel.
REQ-005 SHALL have port bck, input, 1, external bit clock; sdi is valid on the bck rising edge.
REQ-006 SHALL have port sdi, input, 1, serial data, left-justified, MSB first, 16-bit two's complement.
REQ-007 SHALL have port fifo_full, input, 1, write-side full flag of the downstream FIFO.
REQ-008 SHALL have port fifo_wrreq, output, 1, single-clk write strobe.
REQ-009 SHALL have port fifo_data, output, 32, {left[15:0], right[15:0]}, held stable until the next write.
REQ-010 SHALL have port overflow, output, 1, sticky flag: a frame was dropped because fifo_full was high.
REQ-011 SHALL have port frame_err, output, 1, sticky flag: a channel was shorter than 16 bits.

Function
REQ-012 SHALL sample lrck, bck and sdi through SYNC_STAGES flops, then one extra delay flop on lrck and bck for edge detection.
REQ-013 SHALL detect bck_rise as synchronised bck = 1 AND delayed bck = 0.
REQ-014 SHALL detect lrck_edge as synchronised lrck different from delayed lrck.
REQ-015 SHALL implement states ALIGN, LEFT and RIGHT; the reset state SHALL be ALIGN.
REQ-016 ALIGN SHALL go to LEFT on a lrck rising edge; data received before this SHALL be discarded.
REQ-017 LEFT SHALL go to RIGHT on a lrck falling edge; RIGHT SHALL go to LEFT on a lrck rising edge.
REQ-018 On every state entry, the 5-bit bit counter SHALL clear to 0.
REQ-019 On each bck_rise while the counter is below 16, sdi SHALL shift into the channel shift register (MSB first) and the counter SHALL increment.
REQ-020 The counter SHALL saturate at 16; further bck_rise events (32/48/64 fs bck) SHALL be ignored.
REQ-021 When the counter reaches 16 in LEFT, the left register SHALL be held as the frame's left sample.
REQ-022 When the counter reaches 16 in RIGHT, the block SHALL form {left, right} and, on the next clk, either:
  - fifo_full = 0: update fifo_data and pulse fifo_wrreq for exactly one clk; or
  - fifo_full = 1: skip the write, leave fifo_data unchanged, and set overflow.
REQ-023 At most one fifo_wrreq SHALL occur per lrck period.
REQ-024 fifo_wrreq SHALL never assert while in ALIGN.
REQ-025 If a lrck_edge and a bck_rise are detected in the same clk, the edge SHALL win: the counter clears and that bit is not captured (LJ MSB follows the edge).

Reset
REQ-026 While reset_n is low, the block SHALL force state = ALIGN, counter = 0, shift registers = 0, fifo_data = 0, fifo_wrreq = 0, overflow = 0 and frame_err = 0.
REQ-027 Reset asserted mid-frame SHALL abort the partial frame with no write.
REQ-028 After reset release, the block SHALL realign on the next lrck rising edge.

Configuration
REQ-029 With macro LJ_RX_FRAMECHK_EN defined, a lrck_edge arriving in LEFT or RIGHT with counter < 16 SHALL set frame_err.
REQ-030 With LJ_RX_FRAMECHK_EN defined, the short channel SHALL be discarded and no write SHALL occur for that frame.
REQ-031 Without LJ_RX_FRAMECHK_EN, frame_err SHALL be tied to 0 and no frame check SHALL be performed; the short channel is zero-padded in the low bits and written normally.

Verification
REQ-032 Scenario: bck = 64 fs, left = 0x1234, right = 0xFEDC, fifo_full = 0 -> exactly one fifo_wrreq per frame, fifo_data = 0x1234FEDC, overflow = 0.
REQ-033 Scenario: bck = 32 fs, left = 0x8000, right = 0x7FFF -> fifo_data = 0x80007FFF; a 48 fs run with the same data gives an identical result.
REQ-034 Scenario: reset released with lrck low mid-right-channel -> no write until after the first complete left + right frame.
REQ-035 Scenario: fifo_full = 1 for one frame -> no fifo_wrreq and overflow = 1, which stays 1; the following frame with fifo_full = 0 is written normally.
REQ-036 Scenario: LJ_RX_FRAMECHK_EN defined, lrck toggles after 10 left bits -> frame_err = 1 and no write; the next good frame (0xAAAA, 0x5555) is written as 0xAAAA5555.
REQ-037 Scenario: reset_n pulsed low after 8 right bits -> all outputs return to 0 immediately (asynchronously); the next frame after realignment is written correctly.

Source files
------------

// File: rtl/lj_rx.sv
// lj_rx: left-justified serial audio receiver.
// Oversamples lrck/bck/sdi on clk, deserialises 16-bit left and right
// samples and writes {left, right} once per lrck period to a FIFO.
// Optional macro LJ_RX_FRAMECHK_EN enables short-channel detection
// (frame_err); without it short channels are zero-padded and written.
module lj_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lrck,
  input  logic        bck,
  input  logic        sdi,
  input  logic        fifo_full,
  output logic        fifo_wrreq,
  output logic [31:0] fifo_data,
  output logic        overflow,
  output logic        frame_err
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;

  logic [SYNC_STAGES-1:0]   lrck_sync, bck_sync, sdi_sync;
  logic                     lrck_p0, bck_p0, sdi_p0;
  logic                     lrck_p1, bck_p1;
  logic [SYNC_STAGES:0]     prime;
  logic                     armed;
  logic                     lrck_edge, bck_rise;

  state_t                   state;
  logic [4:0]               cnt;
  logic signed [DATA_W-1:0] sr, sr_nxt, left_q;
  logic                     left_ok;
  logic                     vld_p1;
  logic [31:0]              frame_p1;
`ifdef LJ_RX_FRAMECHK_EN
  logic                     frame_err_q;
`endif

  // Bit counter increment that sticks at one full channel.
  function automatic logic [4:0] sat_inc(input logic [4:0] c);
    return (c >= 5'd16) ? 5'd16 : c + 5'd1;
  endfunction

  // Place the next serial bit MSB-first; unfilled low bits stay zero.
  function automatic logic signed [DATA_W-1:0] put_bit(
    input logic signed [DATA_W-1:0] s, input logic [4:0] c, input logic b);
    logic signed [DATA_W-1:0] r;
    r = s;
    r[4'd15 - c[3:0]] = b;
    return r;
  endfunction

  // Synchroniser chains plus one delay flop for edge detection. The prime
  // chain masks the artificial lrck edge produced while the chain refills
  // after reset, so alignment waits for a genuine rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lrck_sync <= '0;
      bck_sync  <= '0;
      sdi_sync  <= '0;
      lrck_p1   <= 1'b0;
      bck_p1    <= 1'b0;
      prime     <= '0;
    end else begin
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], bck};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      lrck_p1   <= lrck_p0;
      bck_p1    <= bck_p0;
      prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Stage p0: synchronised inputs, edge strobes and next shift value.
  always_comb begin
    lrck_p0   = lrck_sync[SYNC_STAGES-1];
    bck_p0    = bck_sync[SYNC_STAGES-1];
    sdi_p0    = sdi_sync[SYNC_STAGES-1];
    armed     = prime[SYNC_STAGES];
    lrck_edge = armed && (lrck_p0 != lrck_p1);
    bck_rise  = bck_p0 && !bck_p1;
    sr_nxt    = put_bit(sr, cnt, sdi_p0);
  end

  // Channel FSM: an lrck edge always wins over a coincident bck rise, since
  // the LJ MSB is presented only after the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ALIGN;
      cnt      <= '0;
      sr       <= '0;
      left_q   <= '0;
      left_ok  <= 1'b0;
      vld_p1   <= 1'b0;
      frame_p1 <= '0;
`ifdef LJ_RX_FRAMECHK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      vld_p1 <= 1'b0;
      if (lrck_edge) begin
        cnt <= '0;
        sr  <= '0;
        case (state)
          ALIGN: begin
            if (lrck_p0) begin
              state   <= LEFT;
              left_ok <= 1'b0;
            end
          end
          LEFT: begin
            if (!lrck_p0) begin
              state <= RIGHT;
              if (cnt < 5'd16) begin
`ifdef LJ_RX_FRAMECHK_EN
                frame_err_q <= 1'b1;
`else
                left_q  <= sr;
                left_ok <= 1'b1;
`endif
              end
            end else begin
              left_ok <= 1'b0;
            end
          end
          RIGHT: begin
            if (lrck_p0) begin
              state   <= LEFT;
              left_ok <= 1'b0;
              if (cnt < 5'd16) begin
`ifdef LJ_RX_FRAMECHK_EN
                frame_err_q <= 1'b1;
`else
                if (left_ok) begin
                  vld_p1   <= 1'b1;
                  frame_p1 <= {left_q, sr};
                end
`endif
              end
            end
          end
          default: state <= ALIGN;
        endcase
      end else if (bck_rise && (state != ALIGN) && (cnt < 5'd16)) begin
        sr  <= sr_nxt;
        cnt <= sat_inc(cnt);
        if (cnt == 5'd15) begin
          if (state == LEFT) begin
            left_q  <= sr_nxt;
            left_ok <= 1'b1;
          end else if (left_ok) begin
            vld_p1   <= 1'b1;
            frame_p1 <= {left_q, sr_nxt};
          end
        end
      end
    end
  end

  // Stage p2: FIFO write or overflow, one clk after the frame is formed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      overflow   <= 1'b0;
    end else begin
      fifo_wrreq <= 1'b0;
      if (vld_p1) begin
        if (!fifo_full) begin
          fifo_data  <= frame_p1;
          fifo_wrreq <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

`ifdef LJ_RX_FRAMECHK_EN
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_lj_rx.sv
// tb_lj_rx: directed bench for lj_rx with hand-computed frame words.
module tb_lj_rx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lrck = 1'b0;
  logic        bck = 1'b0;
  logic        sdi = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_wrreq;
  logic [31:0] fifo_data;
  logic        overflow;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int base;

  lj_rx #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .lrck       (lrck),
    .bck        (bck),
    .sdi        (sdi),
    .fifo_full  (fifo_full),
    .fifo_wrreq (fifo_wrreq),
    .fifo_data  (fifo_data),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Count clk cycles with the write strobe high, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n && fifo_wrreq) wr_count <= wr_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Half a bck period = 4 clk cycles.
  task automatic half();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // One channel: n bck cycles, bits beyond 16 are random filler.
  task automatic send_ch(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bck = 1'b0;
      if (i < 16) sdi = v[15-i];
      else        sdi = 1'($urandom_range(0, 1));
      half();
      bck = 1'b1;
      half();
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int lb, input int rb);
    bck  = 1'b0;
    lrck = 1'b1;
    send_ch(l, lb);
    bck  = 1'b0;
    lrck = 1'b0;
    send_ch(r, rb);
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
    check("rst_data", fifo_data, 32'h0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);

    // Release mid right channel (lrck low): garbage must be discarded.
    reset_n = 1'b1;
    lrck = 1'b0;
    send_ch(16'hDEAD, 8);
    repeat (12) @(posedge clk);
    #1;
    check("align_nowrite", 32'(wr_count), 32'd0);

    // 64 fs frames.
    send_frame(16'h1234, 16'hFEDC, 32, 32);
    check("fs64_cnt1", 32'(wr_count), 32'd1);
    check("fs64_data1", fifo_data, 32'h1234FEDC);
    send_frame(16'h1234, 16'hFEDC, 32, 32);
    check("fs64_cnt2", 32'(wr_count), 32'd2);
    check("fs64_data2", fifo_data, 32'h1234FEDC);
    check("fs64_ovf", 32'(overflow), 32'd0);

    // 32 fs, then a different 64 fs word, then 48 fs with the 32 fs data.
    base = wr_count;
    send_frame(16'h8000, 16'h7FFF, 16, 16);
    check("fs32_cnt", 32'(wr_count - base), 32'd1);
    check("fs32_data", fifo_data, 32'h80007FFF);
    send_frame(16'h1111, 16'h2222, 32, 32);
    check("fs64b_data", fifo_data, 32'h11112222);
    base = wr_count;
    send_frame(16'h8000, 16'h7FFF, 24, 24);
    check("fs48_cnt", 32'(wr_count - base), 32'd1);
    check("fs48_data", fifo_data, 32'h80007FFF);

    // FIFO full for one frame.
    fifo_full = 1'b1;
    base = wr_count;
    send_frame(16'h0BAD, 16'hF00D, 16, 16);
    check("full_cnt", 32'(wr_count - base), 32'd0);
    check("full_ovf", 32'(overflow), 32'd1);
    check("full_data_held", fifo_data, 32'h80007FFF);
    fifo_full = 1'b0;
    base = wr_count;
    send_frame(16'h3C3C, 16'hC3C3, 16, 16);
    check("after_full_cnt", 32'(wr_count - base), 32'd1);
    check("after_full_data", fifo_data, 32'h3C3CC3C3);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Short left channel: 10 bits.
    base = wr_count;
    send_frame(16'h1234, 16'h5678, 10, 16);
`ifdef LJ_RX_FRAMECHK_EN
    check("short_ferr", 32'(frame_err), 32'd1);
    check("short_cnt", 32'(wr_count - base), 32'd0);
    check("short_data", fifo_data, 32'h3C3CC3C3);
`else
    check("short_ferr", 32'(frame_err), 32'd0);
    check("short_cnt", 32'(wr_count - base), 32'd1);
    check("short_data", fifo_data, 32'h12005678);
`endif
    base = wr_count;
    send_frame(16'hAAAA, 16'h5555, 16, 16);
    check("good_cnt", 32'(wr_count - base), 32'd1);
    check("good_data", fifo_data, 32'hAAAA5555);

    // Reset pulse after 8 right bits: asynchronous clear, no write.
    base = wr_count;
    bck  = 1'b0;
    lrck = 1'b1;
    send_ch(16'h0F0F, 16);
    bck  = 1'b0;
    lrck = 1'b0;
    send_ch(16'hF0F0, 8);
    repeat (12) @(posedge clk);
    check("partial_cnt", 32'(wr_count - base), 32'd0);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_wrreq", 32'(fifo_wrreq), 32'd0);
    check("arst_data", fifo_data, 32'h0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_ferr", 32'(frame_err), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    base = wr_count;
    send_frame(16'h7E57, 16'h0001, 16, 16);
    check("realign_cnt", 32'(wr_count - base), 32'd1);
    check("realign_data", fifo_data, 32'h7E570001);
    check("realign_ovf", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
